// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU/MTHI/MTLO and the HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply; otherwise MUL takes 2 cycles.
module mdu #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [2:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        HoldE,
  input  logic        CancelE,
  output logic        MDUReadyE,
  output logic [31:0] HiE,
  output logic [31:0] LoE
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_a, r_b;
  logic [31:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_neg_q;  // also the signed flag for a registered multiply
  logic        r_neg_r;

  logic        w_go, w_is_mul, w_is_div, w_signed_op, w_last;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_shift, w_trial;
  logic        w_ge;
  logic [31:0] w_rem_nx, w_quo_nx, w_q_fix, w_r_fix;
  logic [31:0] w_mul_a, w_mul_b;
  logic        w_mul_s;
  logic [63:0] w_prod;

  assign w_go        = StartE & ~CancelE;
  assign w_is_mul    = (MDUOpE == 3'd0) || (MDUOpE == 3'd1);
  assign w_is_div    = (MDUOpE == 3'd2) || (MDUOpE == 3'd3);
  assign w_signed_op = ~MDUOpE[0];
  assign w_abs_a     = (w_signed_op && SrcAE[31]) ? -SrcAE : SrcAE;
  assign w_abs_b     = (w_signed_op && SrcBE[31]) ? -SrcBE : SrcBE;

  // Restoring step: r_a shifts the dividend out and the quotient in.
  assign w_shift  = {r_rem, r_a[31]};
  assign w_trial  = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_trial[32];
  assign w_rem_nx = w_ge ? w_trial[31:0] : w_shift[31:0];
  assign w_quo_nx = {r_a[30:0], w_ge};
  assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_last   = (r_cnt == 6'(DIV_CYCLES - 1));

`ifdef MDU_FAST_MUL_EN
  assign w_mul_a = SrcAE;
  assign w_mul_b = SrcBE;
  assign w_mul_s = w_signed_op;
`else
  assign w_mul_a = r_a;
  assign w_mul_b = r_b;
  assign w_mul_s = r_neg_q;
`endif

  // Sign-extending to 64 bits makes one unsigned multiplier serve both MULT and MULTU.
  assign w_prod = {{32{w_mul_s & w_mul_a[31]}}, w_mul_a} * {{32{w_mul_s & w_mul_b[31]}}, w_mul_b};

  always_comb begin
    MDUReadyE = 1'b1;
    unique case (r_state)
`ifdef MDU_FAST_MUL_EN
      StIdle:  MDUReadyE = ~(w_go & w_is_div);
`else
      StIdle:  MDUReadyE = ~(w_go & (w_is_mul | w_is_div));
`endif
      StMul:   MDUReadyE = 1'b0;
      StDiv:   MDUReadyE = 1'b0;
      StDone:  MDUReadyE = 1'b1;
      default: MDUReadyE = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_rem   <= 32'd0;
      r_cnt   <= 6'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_go) begin
            if (w_is_div) begin
              r_a     <= w_abs_a;
              r_b     <= w_abs_b;
              r_rem   <= 32'd0;
              r_cnt   <= 6'd0;
              r_neg_q <= w_signed_op & (SrcAE[31] ^ SrcBE[31]);
              r_neg_r <= w_signed_op & SrcAE[31];
              r_state <= StDiv;
            end else if (w_is_mul) begin
`ifdef MDU_FAST_MUL_EN
              r_hi    <= w_prod[63:32];
              r_lo    <= w_prod[31:0];
`else
              r_a     <= SrcAE;
              r_b     <= SrcBE;
              r_neg_q <= w_signed_op;
              r_state <= StMul;
`endif
            end else if (MDUOpE == 3'd4) begin
              r_hi <= SrcAE;
            end else if (MDUOpE == 3'd5) begin
              r_lo <= SrcAE;
            end
          end
        end
        StMul: begin
          if (CancelE) begin
            r_state <= StIdle;
          end else begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= StDone;
          end
        end
        StDiv: begin
          if (CancelE) begin
            r_state <= StIdle;
          end else begin
            r_a   <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_lo    <= w_q_fix;
              r_hi    <= w_r_fix;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          if (CancelE || !HoldE) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign HiE = r_hi;
  assign LoE = r_lo;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and it owns the architectural HI/LO registers. It drives `MDUReadyE` into the hazard unit, which holds IF/ID/EX and bubbles MEM while that signal is low. Division is a 32-iteration radix-2 restoring divider. Multiplication is a registered 2-cycle operation, or single-cycle when configured.

## Interface
- `DIV_CYCLES`, default 32: division iterations; fixed, not to be overridden.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `StartE`  in  1  a valid MDU instruction occupies EX.
- `MDUOpE`  in  3  op select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op.
- `SrcAE`  in  32  forwarded rs operand.
- `SrcBE`  in  32  forwarded rt operand.
- `HoldE`  in  1  external EX stall (MemStall); the instruction stays in EX.
- `CancelE`  in  1  flush of the EX instruction (ExceptDealM); aborts it.
- `MDUReadyE`  out  1  low means the EX instruction must stall.
- `HiE`  out  32  current HI, for MFHI.
- `LoE`  out  32  current LO, for MFLO.

## Operation
- Reset: state IDLE, HI = LO = 0, counter = 0, `MDUReadyE` = 1.
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - With `StartE & ~CancelE` and op MULT/MULTU: latch operands, go to MUL.
  - With the same condition and op DIV/DIVU: latch absolute values and sign flags, clear the remainder, counter = 0, go to DIV.
  - MTHI/MTLO: write `SrcAE` to HI/LO at the edge, stay in IDLE.
- **MDUReadyE** (combinational):
  - In IDLE: `~(StartE & ~CancelE & op ∈ {0..3})`.
  - 0 in MUL and DIV.
  - 1 in DONE.
- **MUL**: register the 64-bit product; signed for MULT, unsigned for MULTU. HI = product[63:32], LO = product[31:0]. Go to DONE.
- **DIV**: one restoring step per cycle. Go to DONE after iteration 31.
  - Signed DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Results: LO = quotient, HI = remainder.
- Divide by zero (not trapped):
  - DIVU: LO = 0xFFFFFFFF, HI = dividend.
  - DIV: sign fix-up is applied to these values.
- 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0.
- **DONE**: HI/LO already hold the result. Stay in DONE while `HoldE`, otherwise go to IDLE. `StartE` is ignored, so the instruction cannot restart.
- **CancelE** in MUL/DIV/DONE: go to IDLE next edge, with no HI/LO write from the aborted op. A cancel in IDLE suppresses the MTHI/MTLO write. CancelE takes priority over HoldE.
- Operands are latched at start. Changes to `SrcAE`/`SrcBE` during MUL/DIV have no effect.

## Timing
- MULT/MULTU: `MDUReadyE` low in cycle 0 (start) and cycle 1 (MUL). HI/LO update at the end of cycle 1. Ready is high in cycle 2, when the instruction leaves EX.
- DIV/DIVU: ready low in cycles 0..32, HI/LO update at the end of cycle 32, ready high in cycle 33. Total 34 EX cycles.
- MTHI/MTLO: 1 cycle, ready never drops.
- `HiE`/`LoE` are register outputs. An MFHI immediately following sees the new value with no forwarding.
- An `rst` assertion mid-operation returns to the reset state immediately.

## Configuration
- `MDU_FAST_MUL_EN`:
  - Defined: MULT/MULTU write HI/LO at the end of the start cycle directly from a combinational 32x32 multiplier. Ready stays 1 and the MUL state is unused.
  - Undefined: the 2-cycle registered path above.
  - Division is unaffected either way.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 -> `HiE`/`LoE` show those values next cycle, and `MDUReadyE` stays 1.
- MULT 0xFFFFFFFF × 0x00000002 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU on the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE. Ready low for exactly 2 cycles (0 cycles with `MDU_FAST_MUL_EN`).
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, ready low for exactly 33 cycles. DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Hold `HoldE` = 1 for 3 cycles after DONE with `StartE` still high -> stays in DONE, no second division, HI/LO unchanged.
- `CancelE` pulsed at DIV iteration 10 -> IDLE next cycle, ready = 1, HI/LO keep their previous values. A following DIVU 9 / 4 -> LO = 2, HI = 1.
